pipe_mem_arbiter: RTL and testbench

Single-port memory arbiter sitting between the pipelined datapath and the unified RAM. It is the responder side of the datapath request/hit protocol. It accepts instruction-fetch and data read/write requests, serialises them onto one RAM port, and returns single-cycle `ihit`/`dhit` pulses with load data. The hazard unit consumes these pulses to decide stalls. Data requests have priority, with a starvation guard for instruction fetch, and the block goes quiescent after a datapath halt.

---
 rtl/pipe_mem_arbiter.sv | 117 +++++++++++
 tb/tb_pipe_mem_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_mem_arbiter.sv
// Single-port RAM arbiter for the pipelined datapath: serialises fetch and data
// requests onto one RAM port and returns one-cycle ihit/dhit pulses.
module pipe_mem_arbiter #(
  parameter int MAX_DGRANT = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        dp_iREN,
  input  logic [31:0] dp_imemaddr,
  input  logic        dp_dREN,
  input  logic        dp_dWEN,
  input  logic [31:0] dp_dmemaddr,
  input  logic [31:0] dp_dmemstore,
  input  logic        dp_halt,
  output logic        dp_ihit,
  output logic [31:0] dp_imemload,
  output logic        dp_dhit,
  output logic [31:0] dp_dmemload,
  output logic        ram_REN,
  output logic        ram_WEN,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_store,
  input  logic [31:0] ram_load,
  input  logic        ram_ready
);

  localparam int CW = $clog2(MAX_DGRANT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_DGRANT);

  typedef enum logic [2:0] {IDLE, IACC, DACC, RESP, HALTED} state_t;
  typedef enum logic [1:0] {K_I, K_DR, K_DW} kind_t;

  state_t        state_q, state_d;
  kind_t         kind_q, kind_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   store_q, store_d;
  logic [31:0]   iload_q, iload_d;
  logic [31:0]   dload_q, dload_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          guard_trip;

  assign guard_trip = (cnt_q == CNT_MAX) && dp_iREN;

  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    addr_d  = addr_q;
    store_d = store_q;
    iload_d = iload_q;
    dload_d = dload_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (dp_halt) begin
          state_d = HALTED;
        end else if ((dp_dREN || dp_dWEN) && !guard_trip) begin
          state_d = DACC;
          addr_d  = {dp_dmemaddr[31:2], 2'b00};
          store_d = dp_dmemstore;
          kind_d  = dp_dWEN ? K_DW : K_DR;
          if (dp_iREN && (cnt_q != CNT_MAX)) cnt_d = cnt_q + 1'b1;
        end else if (dp_iREN) begin
          state_d = IACC;
          addr_d  = {dp_imemaddr[31:2], 2'b00};
          kind_d  = K_I;
          cnt_d   = '0;
        end else begin
          cnt_d = '0;
        end
      end
      IACC, DACC: begin
        if (ram_ready) begin
          state_d = RESP;
          if (kind_q == K_I)  iload_d = ram_load;
          if (kind_q == K_DR) dload_d = ram_load;
        end
      end
      // The served request is still asserted here, so nothing is sampled.
      RESP: begin
        state_d = IDLE;
        if (!dp_iREN) cnt_d = '0;
      end
      HALTED:  state_d = HALTED;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= IDLE;
      kind_q  <= K_I;
      addr_q  <= '0;
      store_q <= '0;
      iload_q <= '0;
      dload_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      addr_q  <= addr_d;
      store_q <= store_d;
      iload_q <= iload_d;
      dload_q <= dload_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ram_REN     = (state_q == IACC) || ((state_q == DACC) && (kind_q == K_DR));
  assign ram_WEN     = (state_q == DACC) && (kind_q == K_DW);
  assign dp_ihit     = (state_q == RESP) && (kind_q == K_I);
  assign dp_dhit     = (state_q == RESP) && (kind_q != K_I);
  assign ram_addr    = addr_q;
  assign ram_store   = store_q;
  assign dp_imemload = iload_q;
  assign dp_dmemload = dload_q;

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// Directed bench for pipe_mem_arbiter: cycle-accurate vector table plus
// hand-written sequences for priority, starvation guard, halt and reset.
module tb_pipe_mem_arbiter;

  logic        CLK;
  logic        nRST;
  logic        dp_iREN, dp_dREN, dp_dWEN, dp_halt;
  logic [31:0] dp_imemaddr, dp_dmemaddr, dp_dmemstore;
  logic        dp_ihit, dp_dhit;
  logic [31:0] dp_imemload, dp_dmemload;
  logic        ram_REN, ram_WEN, ram_ready;
  logic [31:0] ram_addr, ram_store, ram_load;

  int checks = 0;
  int errors = 0;
  int overlap_hits = 0;
  int both_strobes = 0;
  int long_pulses = 0;
  logic prev_ihit = 1'b0;
  logic prev_dhit = 1'b0;

  pipe_mem_arbiter #(.MAX_DGRANT(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .dp_iREN(dp_iREN), .dp_imemaddr(dp_imemaddr),
    .dp_dREN(dp_dREN), .dp_dWEN(dp_dWEN),
    .dp_dmemaddr(dp_dmemaddr), .dp_dmemstore(dp_dmemstore),
    .dp_halt(dp_halt),
    .dp_ihit(dp_ihit), .dp_imemload(dp_imemload),
    .dp_dhit(dp_dhit), .dp_dmemload(dp_dmemload),
    .ram_REN(ram_REN), .ram_WEN(ram_WEN),
    .ram_addr(ram_addr), .ram_store(ram_store),
    .ram_load(ram_load), .ram_ready(ram_ready)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Protocol invariants watched over the whole run.
  always @(negedge CLK) begin
    if (dp_ihit === 1'b1 && dp_dhit === 1'b1) overlap_hits <= overlap_hits + 1;
    if (ram_REN === 1'b1 && ram_WEN === 1'b1) both_strobes <= both_strobes + 1;
    if ((dp_ihit === 1'b1 && prev_ihit) || (dp_dhit === 1'b1 && prev_dhit))
      long_pulses <= long_pulses + 1;
    prev_ihit <= (dp_ihit === 1'b1);
    prev_dhit <= (dp_dhit === 1'b1);
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout actual=running required=finished");
    $fatal(1, "[TB] timeout");
  end

  typedef struct {
    logic        rst_n;
    logic        iren;
    logic [31:0] iaddr;
    logic        dren;
    logic        dwen;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        halt;
    logic        rdy;
    logic [31:0] rload;
    logic        e_ren;
    logic        e_wen;
    logic        e_ihit;
    logic        e_dhit;
    logic [31:0] e_addr;
    logic [31:0] e_store;
    logic [31:0] e_iload;
    logic [31:0] e_dload;
  } vec_t;

  vec_t vecs[13];

  task automatic applyStimulus(input vec_t v);
    nRST         = v.rst_n;
    dp_iREN      = v.iren;
    dp_imemaddr  = v.iaddr;
    dp_dREN      = v.dren;
    dp_dWEN      = v.dwen;
    dp_dmemaddr  = v.daddr;
    dp_dmemstore = v.dstore;
    dp_halt      = v.halt;
    ram_ready    = v.rdy;
    ram_load     = v.rload;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ren"},   32'(ram_REN), 32'd0);
    checkOutput({tag, "_wen"},   32'(ram_WEN), 32'd0);
    checkOutput({tag, "_ihit"},  32'(dp_ihit), 32'd0);
    checkOutput({tag, "_dhit"},  32'(dp_dhit), 32'd0);
    checkOutput({tag, "_addr"},  ram_addr, 32'd0);
    checkOutput({tag, "_store"}, ram_store, 32'd0);
    checkOutput({tag, "_iload"}, dp_imemload, 32'd0);
    checkOutput({tag, "_dload"}, dp_dmemload, 32'd0);
  endtask

  initial begin
    int d_at, i_at, nhits, active, seen;
    byte hits[7];
    string exp_hits;

    //           rst iren iaddr  dren dwen daddr  dstore        halt rdy rload          ren wen ih dh addr   store         iload         dload
    vecs[0]  = '{0, 0, 32'h0,  0, 0, 32'h0,   32'h0,        0, 0, 32'h0,          0, 0, 0, 0, 32'h0,   32'h0,        32'h0,        32'h0};
    vecs[1]  = '{1, 1, 32'h7,  0, 0, 32'h0,   32'h0,        0, 0, 32'h0,          1, 0, 0, 0, 32'h4,   32'h0,        32'h0,        32'h0};
    vecs[2]  = '{1, 1, 32'h40, 0, 0, 32'h0,   32'h0,        0, 0, 32'h0,          1, 0, 0, 0, 32'h4,   32'h0,        32'h0,        32'h0};
    vecs[3]  = '{1, 1, 32'h40, 0, 0, 32'h0,   32'h0,        0, 0, 32'h0,          1, 0, 0, 0, 32'h4,   32'h0,        32'h0,        32'h0};
    vecs[4]  = '{1, 1, 32'h40, 0, 0, 32'h0,   32'h0,        0, 1, 32'hDEADBEEF,   0, 0, 1, 0, 32'h4,   32'h0,        32'hDEADBEEF, 32'h0};
    vecs[5]  = '{1, 0, 32'h0,  0, 0, 32'h0,   32'h0,        0, 0, 32'h0,          0, 0, 0, 0, 32'h4,   32'h0,        32'hDEADBEEF, 32'h0};
    vecs[6]  = '{1, 0, 32'h0,  0, 0, 32'h0,   32'h0,        0, 0, 32'h0,          0, 0, 0, 0, 32'h4,   32'h0,        32'hDEADBEEF, 32'h0};
    vecs[7]  = '{1, 0, 32'h0,  1, 1, 32'h100, 32'h12345678, 0, 0, 32'h0,          0, 1, 0, 0, 32'h100, 32'h12345678, 32'hDEADBEEF, 32'h0};
    vecs[8]  = '{1, 0, 32'h0,  1, 1, 32'h100, 32'h12345678, 0, 1, 32'hAAAA5555,   0, 0, 0, 1, 32'h100, 32'h12345678, 32'hDEADBEEF, 32'h0};
    vecs[9]  = '{1, 0, 32'h0,  0, 0, 32'h0,   32'h0,        0, 0, 32'h0,          0, 0, 0, 0, 32'h100, 32'h12345678, 32'hDEADBEEF, 32'h0};
    vecs[10] = '{1, 0, 32'h0,  1, 0, 32'h203, 32'h0,        0, 1, 32'hCAFEF00D,   1, 0, 0, 0, 32'h200, 32'h0,        32'hDEADBEEF, 32'h0};
    vecs[11] = '{1, 0, 32'h0,  1, 0, 32'h203, 32'h0,        0, 1, 32'hCAFEF00D,   0, 0, 0, 1, 32'h200, 32'h0,        32'hDEADBEEF, 32'hCAFEF00D};
    vecs[12] = '{1, 0, 32'h0,  0, 0, 32'h0,   32'h0,        0, 0, 32'h0,          0, 0, 0, 0, 32'h200, 32'h0,        32'hDEADBEEF, 32'hCAFEF00D};

    applyStimulus(vecs[0]);
    @(negedge CLK);
    for (int i = 0; i < 13; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      applyStimulus(vecs[i]);
      tick();
      checkOutput({tag, "_ren"},   32'(ram_REN), 32'(vecs[i].e_ren));
      checkOutput({tag, "_wen"},   32'(ram_WEN), 32'(vecs[i].e_wen));
      checkOutput({tag, "_ihit"},  32'(dp_ihit), 32'(vecs[i].e_ihit));
      checkOutput({tag, "_dhit"},  32'(dp_dhit), 32'(vecs[i].e_dhit));
      checkOutput({tag, "_addr"},  ram_addr,     vecs[i].e_addr);
      checkOutput({tag, "_store"}, ram_store,    vecs[i].e_store);
      checkOutput({tag, "_iload"}, dp_imemload,  vecs[i].e_iload);
      checkOutput({tag, "_dload"}, dp_dmemload,  vecs[i].e_dload);
    end

    // Data wins over a simultaneous fetch; fetch follows three cycles later.
    dp_iREN = 1; dp_imemaddr = 32'h300;
    dp_dREN = 1; dp_dmemaddr = 32'h400;
    ram_ready = 1; ram_load = 32'h11112222;
    d_at = -1; i_at = -1;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      tick();
      if (dp_dhit) begin d_at = cyc; dp_dREN = 0; end
      if (dp_ihit) begin i_at = cyc; dp_iREN = 0; break; end
    end
    checkOutput("prio_dhit_cycle", 32'(d_at), 32'd2);
    checkOutput("prio_ihit_after_dhit", 32'(i_at - d_at), 32'd3);
    checkOutput("prio_imemload", dp_imemload, 32'h11112222);
    checkOutput("prio_dmemload", dp_dmemload, 32'h11112222);
    tick();

    // Starvation guard: four data grants, then the pending fetch is forced.
    dp_iREN = 1; dp_imemaddr = 32'h800;
    dp_dWEN = 1; dp_dmemaddr = 32'h900; dp_dmemstore = 32'h5;
    ram_ready = 1;
    nhits = 0;
    for (int cyc = 0; cyc < 80 && nhits < 7; cyc++) begin
      tick();
      if (dp_dhit) begin hits[nhits] = "D"; nhits++; end
      if (dp_ihit) begin hits[nhits] = "I"; nhits++; dp_iREN = 0; end
    end
    dp_dWEN = 0;
    checkOutput("guard_hit_count", 32'(nhits), 32'd7);
    exp_hits = "DDDDIDD";
    for (int k = 0; k < 7; k++) begin
      byte h;
      h = (k < nhits) ? hits[k] : "-";
      checkOutput($sformatf("guard_hit%0d", k), 32'(h), 32'(exp_hits[k]));
    end
    tick();
    tick();

    // Halt raised mid-access: hit still delivered, then quiescent.
    dp_dREN = 1; dp_dmemaddr = 32'h500; ram_ready = 0;
    tick();
    checkOutput("halt_dacc_ren", 32'(ram_REN), 32'd1);
    dp_halt = 1;
    for (int k = 0; k < 3; k++) tick();
    checkOutput("halt_wait_ren", 32'(ram_REN), 32'd1);
    ram_ready = 1; ram_load = 32'h0BADF00D;
    tick();
    checkOutput("halt_dhit", 32'(dp_dhit), 32'd1);
    checkOutput("halt_dmemload", dp_dmemload, 32'h0BADF00D);
    dp_dREN = 0; ram_ready = 0;
    tick();
    tick();
    dp_iREN = 1; dp_dREN = 1; ram_ready = 1;
    active = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (ram_REN || ram_WEN || dp_ihit || dp_dhit) active++;
    end
    checkOutput("halted_activity", 32'(active), 32'd0);
    checkOutput("halted_dload_held", dp_dmemload, 32'h0BADF00D);
    nRST = 0; dp_halt = 0; dp_iREN = 0; dp_dREN = 0;
    tick();
    checkAllZero("halt_reset");
    nRST = 1; dp_iREN = 1; dp_imemaddr = 32'h604; ram_load = 32'h13572468;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (dp_ihit) begin seen = 1; break; end
    end
    checkOutput("halt_release_ihit", 32'(seen), 32'd1);
    checkOutput("halt_release_iload", dp_imemload, 32'h13572468);
    dp_iREN = 0;
    tick();

    // Reset in the middle of a fetch aborts it without a hit.
    dp_iREN = 1; dp_imemaddr = 32'h700; ram_ready = 0; ram_load = 32'hFFFF0000;
    tick();
    checkOutput("rst_iacc_ren", 32'(ram_REN), 32'd1);
    checkOutput("rst_iacc_addr", ram_addr, 32'h700);
    nRST = 0;
    tick();
    checkAllZero("rst_mid");
    nRST = 1; dp_iREN = 0; ram_ready = 1;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (dp_ihit) seen++;
    end
    checkOutput("rst_no_ihit", 32'(seen), 32'd0);
    dp_iREN = 1; dp_imemaddr = 32'h808; ram_load = 32'h89ABCDEF;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (dp_ihit) begin seen = 1; break; end
    end
    checkOutput("rst_fresh_ihit", 32'(seen), 32'd1);
    checkOutput("rst_fresh_iload", dp_imemload, 32'h89ABCDEF);
    checkOutput("rst_fresh_addr", ram_addr, 32'h808);
    dp_iREN = 0;
    tick();
    tick();

    checkOutput("inv_hit_overlap", 32'(overlap_hits), 32'd0);
    checkOutput("inv_strobe_overlap", 32'(both_strobes), 32'd0);
    checkOutput("inv_long_pulse", 32'(long_pulses), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
